// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and helpers for the writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned REG_BUS      = 32;
  localparam int unsigned CNT_W        = 16;

  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = 5'd0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  // Index width for n sources, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational rotate-priority encoder: first requester at or after ptr wins.
module regfile_wb_arbiter_rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;

  // Walk offsets from the pointer; the first valid source in that order is granted.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!found && req_i[i] && (((int'(ptr_i) + k) % int'(NUM_REQ)) == i)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among writeback sources.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = REG_ADDR_BUS,
  parameter int unsigned DATA_W  = REG_BUS,
  localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [IDX_W-1:0]            grant_id,
  output logic [CNT_W-1:0]            wr_count
);

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic               rf_we_q,    rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;

  regfile_wb_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Grants are suppressed during reset so no source believes it was accepted.
  assign req_ready = (rst == RST_ENABLE) ? '0 : gnt;
  assign accept    = |req_ready;

  // One-hot grant makes an OR-mux sufficient for the winning payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for pointer, output stage and write counter; x0 writes are consumed silently.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = WRITE_DISABLE;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    grant_id_d = grant_id_q;
    wr_count_d = wr_count_q;
    if (accept) begin
      rr_ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
      grant_id_d = gnt_idx;
      rf_we_d    = (sel_addr != ADDR_W'(NOP_REG_ADDR)) ? WRITE_ENABLE : WRITE_DISABLE;
    end
    if (rf_we_d == WRITE_ENABLE) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= WRITE_DISABLE;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
      wr_count_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign grant_id = grant_id_q;
  assign wr_count = wr_count_q;

endmodule
